// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and sizing helpers for sync_fifo_prog
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;
  typedef logic [cnt_w(DEFAULT_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH dual-port register array; registered read, or
// fall-through read with a hold register when FIFO_FWFT_EN is defined
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Holds the last word read (or presented, in fall-through mode) while re is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = re ? r_mem[raddr] : r_rdata;
`else
  assign rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - synchronous FIFO with programmable almost-full/empty thresholds
// and overflow/underflow pulses; FIFO_FWFT_EN selects first-word fall-through reads
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] fifo_counter,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_re;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_ok = rd_en && !w_empty;
  // A full FIFO still takes a write when the head is popped in the same cycle
  assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr_en && !w_wr_ok;
      r_underflow <= rd_en && !w_rd_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  assign w_re = !w_empty;
`else
  assign w_re = w_rd_ok;
`endif

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_ok),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .re    (w_re),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign data_out     = w_rdata;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign fifo_counter = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed plus random stimulus against a queue model of
// sync_fifo_prog; honours FIFO_FWFT_EN
module tb_sync_fifo_prog;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] af_thresh = '0;
  logic [CNT_W-1:0] ae_thresh = '0;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] fifo_counter;
  logic             overflow;
  logic             underflow;

  int total = 0;
  int bad   = 0;

  int q[$];
  int exp_dout  = 0;
  int last_pres = 0;
  bit exp_ovf   = 1'b0;
  bit exp_udf   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_counter (fifo_counter),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit w, input int d, input bit r, input bit rs);
    bit rd_ok;
    bit wr_ok;
    int exp_dv;
    wr_en   = w;
    data_in = WIDTH'(d);
    rd_en   = r;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      exp_dout  = 0;
      last_pres = 0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d & MASK);
      exp_ovf = w && !wr_ok;
      exp_udf = r && !rd_ok;
    end
`ifdef FIFO_FWFT_EN
    if (q.size() > 0) last_pres = q[0];
    exp_dv = last_pres;
`else
    exp_dv = exp_dout;
`endif
    #1;
    check("count", 32'(fifo_counter), q.size());
    check("full", 32'(full), (q.size() == DEPTH) ? 1 : 0);
    check("empty", 32'(empty), (q.size() == 0) ? 1 : 0);
    check("almost_full", 32'(almost_full), (q.size() >= int'(af_thresh)) ? 1 : 0);
    check("almost_empty", 32'(almost_empty), (q.size() <= int'(ae_thresh)) ? 1 : 0);
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("underflow", 32'(underflow), 32'(exp_udf));
    check("data_out", 32'(data_out), exp_dv);
  endtask

  initial begin
    int pw;
    int pr;

    // 1: reset, push 1,2, pop once
    step(0, 0, 0, 1);
    check("rst_af_at_zero_thresh", 32'(almost_full), 1);
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(0, 0, 1, 0);
    check("t1_count", 32'(fifo_counter), 1);
    check("t1_empty", 32'(empty), 0);
`ifndef FIFO_FWFT_EN
    check("t1_dout", 32'(data_out), 1);
`endif

    // 2: thresholds and filling to full from empty
    step(0, 0, 0, 1);
    af_thresh = 5'd14;
    ae_thresh = 5'd2;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, i + 3, 0, 0);
      if (q.size() == 3)  check("t2_ae_drop", 32'(almost_empty), 0);
      if (q.size() == 13) check("t2_af_low", 32'(almost_full), 0);
      if (q.size() == 14) check("t2_af_rise", 32'(almost_full), 1);
    end
    check("t2_full", 32'(full), 1);
    step(1, 1, 0, 0);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_cnt16", 32'(fifo_counter), 16);
    step(0, 0, 0, 0);
    check("t2_ovf_pulse", 32'(overflow), 0);

    // 3: simultaneous read/write when full, then drain across the wrap
    step(1, 9, 1, 0);
    check("t3_cnt", 32'(fifo_counter), 16);
    check("t3_no_ovf", 32'(overflow), 0);
    repeat (DEPTH) step(0, 0, 1, 0);
    check("t3_drained", 32'(empty), 1);
`ifndef FIFO_FWFT_EN
    check("t3_last9", 32'(data_out), 9);
`endif

    // 4: underflow, then simultaneous access on empty
    step(0, 0, 1, 0);
    check("t4_udf", 32'(underflow), 1);
    check("t4_cnt0", 32'(fifo_counter), 0);
    step(0, 0, 0, 0);
    check("t4_udf_pulse", 32'(underflow), 0);
    step(1, 6, 1, 0);
    check("t4_both_cnt", 32'(fifo_counter), 1);
    check("t4_both_udf", 32'(underflow), 1);

    // 5: reset mid-stream at count 7
    for (int i = 0; i < 6; i++) step(1, 10 + i, 0, 0);
    check("t5_cnt7", 32'(fifo_counter), 7);
    step(0, 0, 0, 1);
    check("t5_rst_cnt", 32'(fifo_counter), 0);
    check("t5_rst_empty", 32'(empty), 1);
    check("t5_rst_dout", 32'(data_out), 0);
    step(1, 5, 0, 0);
    step(0, 0, 1, 0);
    check("t5_fresh", 32'(data_out), 5);

`ifdef FIFO_FWFT_EN
    // 6: fall-through presents the head word without rd_en
    step(1, 4, 0, 0);
    check("t6_fwft_dout", 32'(data_out), 4);
    step(0, 0, 1, 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_cnt", 32'(fifo_counter), 0);
`endif

    // Random traffic with shifting bias, thresholds (incl. out of range) and rare resets
    pw = 50;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
        af_thresh = CNT_W'($urandom_range(0, 31));
        ae_thresh = CNT_W'($urandom_range(0, 31));
      end
      step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
           $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
